al_accel_quant_pack: RTL
========================

// Module: al_accel_quant_pack
// PURPOSE
// - Downstream of al_accel_quant_unit: collects its int8 results (quant_do) into 32-bit words for output-buffer writeback.
// - Packs bytes little-endian into words, with byte strobe and a last flag. Burst length is programmable.
// - A small word FIFO decouples the packer from writeback stalls.
// PARAMETERS
// - FIFO_DEPTH  4   output word FIFO depth; power of 2, >=2
// - LEN_W       16  width of burst byte-length counter
// PORTS
// - clk        in   1      clock
// - resetn     in   1      synchronous active-low reset
// - enb        in   1      global enable; 0 = freeze all state
// - start      in   1      start burst (sampled only in IDLE)
// - cfg_len    in   LEN_W  bytes in burst, latched on start
// - in_valid   in   1      quant byte valid
// - in_data    in   8      quant byte (signed int8, from quant_do)
// - in_ready   out  1      packer accepts byte
// - out_valid  out  1      FIFO head word valid
// - out_data   out  32     packed word; byte k at [8k+7:8k]
// - out_strb   out  4      valid byte lanes of out_data
// - out_last   out  1      final word of burst
// - out_ready  in   1      writeback accepts word
// - busy       out  1      state != IDLE
// - done       out  1      one-cycle pulse at burst completion
// BEHAVIOUR
// - Reset (resetn=0 at posedge): state=IDLE, FIFO empty, byte/word counters=0, assembly reg=0.
// - Reset values: all outputs 0.
// - Reset mid-burst aborts it: partial words and FIFO contents are discarded; no done pulse.
// - enb=0:
//   - all registers hold.
//   - in_ready and out_valid are forced 0, so no transfer occurs.
//   - done cannot pulse.
// - FSM states: IDLE, PACK, DRAIN, DONE.
//   - IDLE: start=1 latches cfg_len. Nonzero length -> PACK; cfg_len=0 -> DONE.
//   - PACK: in_ready = !fifo_full.
//     - Each accepted byte (in_valid&in_ready) is written to lane cnt[1:0]; cnt increments.
//     - A word is pushed when lane 3 is filled, or when the final byte (cnt==len-1) is accepted.
//     - The push occurs the same cycle the byte is accepted.
//     - Pushed entry = {assembled data, strb, last}.
//     - The final word sets last=1 and moves the FSM to DRAIN.
//     - Unfilled lanes of a partial word are 0 in out_data, with strb=0 for those lanes (len%4=1 -> 4'b0001).
//   - DRAIN: in_ready=0. Wait until FIFO is empty (after the last pop), then -> DONE.
//   - DONE: done=1 for exactly one cycle, then -> IDLE.
// - start outside IDLE is ignored.
// - in_valid is ignored outside PACK.
// - FIFO behaviour:
//   - out_valid = !empty; out_data/strb/last are driven from the head entry.
//   - A pop occurs on out_valid&out_ready.
//   - Simultaneous push and pop (including when full) leaves the count unchanged; no data loss.
//   - in_ready is based on the registered full flag, so no push into a full FIFO.
// - Latency: a byte completing a word at posedge N appears on out_valid after posedge N (next cycle) when the FIFO was empty.
// - Zero bubbles at full throughput: 1 byte/cycle in, 1 word per 4 cycles out.
// - Pointer and counter wrap: FIFO pointers use log2(FIFO_DEPTH)+1 bits; cnt never exceeds cfg_len.
// CONFIGURATION
// - Macro ACT_RELU_EN:
//   - Defined: each accepted byte with bit7=1 is replaced by 8'h00 before packing (fused ReLU); strb is unaffected.
//   - Undefined: bytes are packed unchanged (signed int8 passthrough).
// TESTING
// - T1: cfg_len=8, bytes 01..08 back-to-back, out_ready=1
//   -> 32'h04030201 strb F last 0; then 32'h08070605 strb F last 1; done pulses once, after the final pop.
// - T2: cfg_len=5, bytes 11..15
//   -> 32'h14131211 strb F; then 32'h00000015 strb 1 last 1.
// - T3: cfg_len=24, out_ready=0
//   -> after 16 bytes, 4 words are queued and in_ready=0.
//   -> Raise out_ready: 6 words emerge in order, no loss or duplication, done after the 6th.
// - T4: enb=0 for 3 cycles mid-burst with in_valid=1
//   -> no handshakes, counters held; the stream resumes intact with enb=1.
// - T5: resetn=0 mid-burst -> all outputs 0 at next posedge, FSM IDLE.
//   -> Then start with cfg_len=0 -> busy for 1 cycle, done pulse, no out_valid.
// - T6: bytes 80,FF,7F,01 (cfg_len=4)
//   -> with ACT_RELU_EN: 32'h017F0000.
//   -> without ACT_RELU_EN: 32'h017FFF80.

Source files
------------

// File: rtl/al_accel_quant_pack.sv
// al_accel_quant_pack
// Collects int8 results from the quant unit into little-endian 32-bit words
// for output-buffer writeback. The burst length in bytes is programmable. A
// small word FIFO decouples byte packing from writeback stalls.
//
// Optional feature macro: ACT_RELU_EN
//   defined   - every accepted byte with bit7 set is replaced by 8'h00 before
//               it is packed (fused ReLU). The byte strobe is not affected.
//   undefined - bytes are packed unchanged (signed int8 passthrough).
//
// Parameters
//   FIFO_DEPTH  word FIFO depth (power of 2, >= 2)
//   LEN_W       width of the burst byte-length register and byte counter
//
// Ports
//   clk        clock
//   resetn     synchronous active-low reset
//   enb        global enable; 0 freezes all state and blocks both handshakes
//   start      starts a burst (sampled only in IDLE)
//   cfg_len    number of bytes in the burst, latched on start
//   in_valid   quant byte valid
//   in_data    quant byte
//   in_ready   packer accepts a byte
//   out_valid  FIFO head word valid
//   out_data   packed word; byte k is at [8k+7:8k]
//   out_strb   valid byte lanes of out_data
//   out_last   final word of the burst
//   out_ready  writeback accepts a word
//   busy       FSM not in IDLE
//   done       one-cycle pulse at burst completion
module al_accel_quant_pack #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enb,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [3:0]       out_strb,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  // Lanes 0..2 only: a byte for lane 3 always completes and pushes the word.
  logic [23:0]      asm_q, asm_d;

  // FIFO storage and pointers; the extra pointer MSB separates full from empty.
  logic [31:0]      mem_data_q [FIFO_DEPTH];
  logic [3:0]       mem_strb_q [FIFO_DEPTH];
  logic             mem_last_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  logic             empty_s;
  logic             full_s;
  logic [7:0]       byte_s;
  logic             accept_s;
  logic             last_byte_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      word_s;
  logic [3:0]       strb_s;

`ifdef ACT_RELU_EN
  assign byte_s = in_data[7] ? 8'h00 : in_data;
`else
  assign byte_s = in_data;
`endif

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Handshakes only exist while enabled; in_ready uses the registered full
  // flag, so a push can never land in a full FIFO.
  assign in_ready    = enb && (state_q == ST_PACK) && !full_s;
  assign out_valid   = enb && !empty_s;
  assign accept_s    = in_valid && in_ready;
  assign pop_s       = out_valid && out_ready;
  // len_q is nonzero whenever the FSM is in PACK.
  assign last_byte_s = (cnt_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));
  assign push_s      = accept_s && ((cnt_q[1:0] == 2'd3) || last_byte_s);

  // Head entry drives the word outputs; zero while the FIFO is empty.
  assign out_data = empty_s ? 32'h0000_0000 : mem_data_q[rd_ptr_q[AW-1:0]];
  assign out_strb = empty_s ? 4'b0000       : mem_strb_q[rd_ptr_q[AW-1:0]];
  assign out_last = empty_s ? 1'b0          : mem_last_q[rd_ptr_q[AW-1:0]];
  assign busy     = (state_q != ST_IDLE);
  assign done     = enb && (state_q == ST_DONE);

  // Merge the incoming byte into its lane and build the strobe for the lanes filled so far.
  always_comb begin
    word_s = {8'h00, asm_q};
    strb_s = 4'b0000;
    case (cnt_q[1:0])
      2'd0: begin word_s[7:0]   = byte_s; strb_s = 4'b0001; end
      2'd1: begin word_s[15:8]  = byte_s; strb_s = 4'b0011; end
      2'd2: begin word_s[23:16] = byte_s; strb_s = 4'b0111; end
      2'd3: begin word_s[31:24] = byte_s; strb_s = 4'b1111; end
      default: begin word_s = 32'h0000_0000; strb_s = 4'b0000; end
    endcase
  end

  // FSM next state plus burst length, byte counter and assembly register.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          cnt_d   = {LEN_W{1'b0}};
          asm_d   = 24'h00_0000;
          state_d = (cfg_len != {LEN_W{1'b0}}) ? ST_PACK : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PACK: begin
        if (accept_s) begin
          cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
          // Clearing after a push keeps unfilled lanes of a partial word zero.
          asm_d = push_s ? 24'h00_0000 : word_s[23:0];
          if (last_byte_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_PACK;
          end
        end else begin
          state_d = ST_PACK;
        end
      end
      ST_DRAIN: begin
        if (empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and FIFO pointers; enb=0 holds everything.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      len_q    <= {LEN_W{1'b0}};
      cnt_q    <= {LEN_W{1'b0}};
      asm_q    <= 24'h00_0000;
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else if (enb) begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO entry write; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= word_s;
      mem_strb_q[wr_ptr_q[AW-1:0]] <= strb_s;
      mem_last_q[wr_ptr_q[AW-1:0]] <= last_byte_s;
    end
  end

endmodule
